// File: rtl/frame_buffer_writer_pkg.sv
// Shared definitions for the frame buffer writer: FSM states, component codes
// and the default active-image geometry used by the display path.
package frame_buffer_writer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HUNT,
        WR_R,
        WR_G,
        WR_B,
        COMMIT
    } state_t;

    localparam logic [1:0] COMP_R = 2'd0;
    localparam logic [1:0] COMP_G = 2'd1;
    localparam logic [1:0] COMP_B = 2'd2;

    localparam int unsigned DEF_ACT_PIXELS = 10;
    localparam int unsigned DEF_ACT_LINES  = 10;

    function automatic logic [1:0] comp_for(state_t s);
        logic [1:0] c;
        c = COMP_B;
        if (s == WR_R) c = COMP_R;
        else if (s == WR_G) c = COMP_G;
        return c;
    endfunction

endpackage

// File: rtl/frame_buffer_writer_release_edge.sv
// Rising-edge detector for a buffer-empty level coming from the display
// controller; one instance per ping-pong buffer.
module release_edge (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic level_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) level_d <= 1'b0;
        else       level_d <= level;
    end

    assign rise = level & ~level_d;

endmodule

// File: rtl/frame_buffer_writer.sv
// Writes an R,G,B byte stream into alternating ping-pong frame buffers and
// tracks which buffers hold a complete frame for the display controller.
module frame_buffer_writer
    import frame_buffer_writer_pkg::*;
#(
    parameter int unsigned ACT_PIXELS = DEF_ACT_PIXELS,
    parameter int unsigned ACT_LINES  = DEF_ACT_LINES,
    parameter int unsigned ADDR_W     = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              in_sof,
    output logic              in_ready,
    input  logic              buf0_empty,
    input  logic              buf1_empty,
    output logic              wr_en0,
    output logic              wr_en1,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [1:0]        wr_sel,
    output logic [7:0]        wr_data,
    output logic              buf0_full,
    output logic              buf1_full,
    output logic              sync_err
);

    localparam logic [9:0] PX_LAST = 10'(ACT_PIXELS - 1);
    localparam logic [9:0] LN_LAST = 10'(ACT_LINES - 1);

    state_t            state;
    logic              tgt;
    logic [9:0]        px_cnt;
    logic [9:0]        line_cnt;
    logic [ADDR_W-1:0] addr;
    logic              full0;
    logic              full1;
    logic              rel0;
    logic              rel1;
    logic              accept;
    logic              tgt_full;

    release_edge u_rel0 (
        .clk   (clk),
        .reset (reset),
        .level (buf0_empty),
        .rise  (rel0)
    );

    release_edge u_rel1 (
        .clk   (clk),
        .reset (reset),
        .level (buf1_empty),
        .rise  (rel1)
    );

    assign accept    = in_valid & in_ready;
    assign tgt_full  = tgt ? full1 : full0;
    assign buf0_full = full0;
    assign buf1_full = full1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            tgt      <= 1'b0;
            px_cnt   <= '0;
            line_cnt <= '0;
            addr     <= '0;
            full0    <= 1'b0;
            full1    <= 1'b0;
            in_ready <= 1'b0;
            wr_en0   <= 1'b0;
            wr_en1   <= 1'b0;
            wr_addr  <= '0;
            wr_sel   <= '0;
            wr_data  <= '0;
            sync_err <= 1'b0;
        end else begin
            wr_en0   <= 1'b0;
            wr_en1   <= 1'b0;
            sync_err <= 1'b0;

            // Releases are applied before COMMIT so a coincident set of the same flag wins.
            if (rel0) full0 <= 1'b0;
            if (rel1) full1 <= 1'b0;

            case (state)
                IDLE: begin
                    if (!tgt_full) begin
                        state    <= HUNT;
                        in_ready <= 1'b1;
                    end
                end

                HUNT: begin
                    if (accept && in_sof) begin
                        if (tgt) wr_en1 <= 1'b1;
                        else     wr_en0 <= 1'b1;
                        wr_addr <= '0;
                        wr_sel  <= COMP_R;
                        wr_data <= in_data;
                        state   <= WR_G;
                    end
                end

                WR_R, WR_G, WR_B: begin
                    if (accept) begin
                        if (tgt) wr_en1 <= 1'b1;
                        else     wr_en0 <= 1'b1;
                        wr_data <= in_data;
                        if (in_sof) begin
                            // Misplaced start of frame: restart the same buffer at pixel 0.
                            sync_err <= 1'b1;
                            px_cnt   <= '0;
                            line_cnt <= '0;
                            addr     <= '0;
                            wr_addr  <= '0;
                            wr_sel   <= COMP_R;
                            state    <= WR_G;
                        end else begin
                            wr_addr <= addr;
                            wr_sel  <= comp_for(state);
                            case (state)
                                WR_R: state <= WR_G;
                                WR_G: state <= WR_B;
                                default: begin
                                    if (px_cnt == PX_LAST && line_cnt == LN_LAST) begin
                                        px_cnt   <= '0;
                                        line_cnt <= '0;
                                        addr     <= '0;
                                        in_ready <= 1'b0;
                                        state    <= COMMIT;
                                    end else begin
                                        addr <= addr + ADDR_W'(1);
                                        if (px_cnt == PX_LAST) begin
                                            px_cnt   <= '0;
                                            line_cnt <= line_cnt + 10'd1;
                                        end else begin
                                            px_cnt <= px_cnt + 10'd1;
                                        end
                                        state <= WR_R;
                                    end
                                end
                            endcase
                        end
                    end
                end

                COMMIT: begin
                    if (tgt) full1 <= 1'b1;
                    else     full0 <= 1'b1;
                    tgt      <= ~tgt;
                    px_cnt   <= '0;
                    line_cnt <= '0;
                    addr     <= '0;
                    in_ready <= 1'b0;
                    state    <= IDLE;
                end

                default: begin
                    in_ready <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Directed-sequence bench with random pixel data, checked against a byte-level
// model of frame assembly, buffer alternation and full/release bookkeeping.
module tb_frame_buffer_writer;

    localparam int unsigned P  = 10;
    localparam int unsigned L  = 10;
    localparam int unsigned AW = 7;
    localparam int FRAME_BYTES = 3 * P * L;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_sof;
    logic          in_ready;
    logic          buf0_empty;
    logic          buf1_empty;
    logic          wr_en0;
    logic          wr_en1;
    logic [AW-1:0] wr_addr;
    logic [1:0]    wr_sel;
    logic [7:0]    wr_data;
    logic          buf0_full;
    logic          buf1_full;
    logic          sync_err;

    always #5 clk = ~clk;

    frame_buffer_writer #(
        .ACT_PIXELS (P),
        .ACT_LINES  (L),
        .ADDR_W     (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_ready   (in_ready),
        .buf0_empty (buf0_empty),
        .buf1_empty (buf1_empty),
        .wr_en0     (wr_en0),
        .wr_en1     (wr_en1),
        .wr_addr    (wr_addr),
        .wr_sel     (wr_sel),
        .wr_data    (wr_data),
        .buf0_full  (buf0_full),
        .buf1_full  (buf1_full),
        .sync_err   (sync_err)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: byte index within the frame being assembled.
    bit         mtgt;
    int         idx;
    bit         hunting;
    bit         exp_full [2];
    int         cd_commit;
    int         commit_buf;
    int         cd_rel [2];
    bit         exp_wr;
    bit         exp_buf;
    bit         exp_sync;
    int         exp_addr;
    int         exp_sel;
    logic [7:0] exp_data;
    bit         e_req [2];
    bit         e_prev [2];
    int         n_en0 = 0;
    int         n_en1 = 0;
    int         n_sync = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        mtgt = 1'b0; idx = 0; hunting = 1'b1;
        exp_full[0] = 1'b0; exp_full[1] = 1'b0;
        cd_commit = 0; commit_buf = 0;
        cd_rel[0] = 0; cd_rel[1] = 0;
        exp_wr = 1'b0; exp_buf = 1'b0; exp_sync = 1'b0;
        exp_addr = 0; exp_sel = 0; exp_data = '0;
        e_prev[0] = 1'b0; e_prev[1] = 1'b0;
    endtask

    task automatic model_accept(input logic [7:0] d, input bit s);
        bit write;
        write = 1'b0;
        if (s) begin
            if (!hunting && idx != 0) exp_sync = 1'b1;
            idx = 0;
            hunting = 1'b0;
            write = 1'b1;
        end else if (!hunting) begin
            write = 1'b1;
        end
        if (write) begin
            exp_wr   = 1'b1;
            exp_buf  = mtgt;
            exp_addr = idx / 3;
            exp_sel  = idx % 3;
            exp_data = d;
            idx++;
            if (idx == FRAME_BYTES) begin
                cd_commit  = 2;
                commit_buf = int'(mtgt);
                mtgt       = ~mtgt;
                idx        = 0;
                hunting    = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        for (int b = 0; b < 2; b++) begin
            if (cd_rel[b] > 0) begin
                cd_rel[b]--;
                if (cd_rel[b] == 0) exp_full[b] = 1'b0;
            end
        end
        if (cd_commit > 0) begin
            cd_commit--;
            if (cd_commit == 0) exp_full[commit_buf] = 1'b1;
        end
        chk("wr_en", 32'({wr_en1, wr_en0}), 32'(exp_wr ? (exp_buf ? 2'b10 : 2'b01) : 2'b00));
        if (exp_wr) begin
            chk("wr_addr", 32'(wr_addr), 32'(exp_addr));
            chk("wr_sel", 32'(wr_sel), 32'(exp_sel));
            chk("wr_data", 32'(wr_data), 32'(exp_data));
        end
        chk("sync_err", 32'(sync_err), 32'(exp_sync));
        chk("buf0_full", 32'(buf0_full), 32'(exp_full[0]));
        chk("buf1_full", 32'(buf1_full), 32'(exp_full[1]));
        if (in_ready === 1'b1) chk("ready_target_free", 32'(exp_full[mtgt]), 32'(0));
        if (wr_en0 === 1'b1) n_en0++;
        if (wr_en1 === 1'b1) n_en1++;
        if (sync_err === 1'b1) n_sync++;
    endtask

    // One clock: check last cycle's results, then drive this cycle's inputs.
    task automatic cycle(input bit v, input logic [7:0] d, input bit s, output bit acc);
        @(negedge clk);
        check_outputs();
        acc = v && (in_ready === 1'b1);
        in_valid = v;
        in_data  = d;
        in_sof   = s;
        for (int b = 0; b < 2; b++) begin
            if (e_req[b] && !e_prev[b]) cd_rel[b] = 1;
            e_prev[b] = e_req[b];
        end
        buf0_empty = e_req[0];
        buf1_empty = e_req[1];
        exp_wr   = 1'b0;
        exp_sync = 1'b0;
        if (acc) model_accept(d, s);
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, a);
    endtask

    task automatic send_byte(input logic [7:0] d, input bit s);
        bit acc;
        acc = 1'b0;
        for (int t = 0; t < 64 && !acc; t++) cycle(1'b1, d, s, acc);
        if (!acc) begin
            checks++;
            errors++;
            $error("FAIL accept_timeout: observed=no_accept expected=accept");
        end
    endtask

    task automatic send_frame(input int nbytes, input int gap);
        for (int i = 0; i < nbytes; i++) begin
            send_byte(8'($urandom_range(0, 255)), i == 0);
            idle(gap);
        end
    endtask

    task automatic check_reset_values();
        chk("rst_in_ready", 32'(in_ready), 32'(0));
        chk("rst_wr_en", 32'({wr_en1, wr_en0}), 32'(0));
        chk("rst_wr_addr", 32'(wr_addr), 32'(0));
        chk("rst_wr_sel", 32'(wr_sel), 32'(0));
        chk("rst_wr_data", 32'(wr_data), 32'(0));
        chk("rst_full", 32'({buf1_full, buf0_full}), 32'(0));
        chk("rst_sync_err", 32'(sync_err), 32'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        check_outputs();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = '0;
        reset    = 1'b1;
        #1;
        check_reset_values();
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int b0, b1, s0;
        bit a;
        reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
        buf0_empty = 1'b0; buf1_empty = 1'b0;
        e_req[0] = 1'b0; e_req[1] = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_values();
        reset = 1'b0;
        idle(2);

        // Frame into buffer 0, continuous valid; two not-ready cycles afterwards.
        b0 = n_en0; b1 = n_en1;
        send_frame(FRAME_BYTES, 0);
        idle(1); chk("gap_commit_ready", 32'(in_ready), 32'(0));
        idle(1); chk("gap_idle_ready", 32'(in_ready), 32'(0));
        idle(1); chk("gap_hunt_ready", 32'(in_ready), 32'(1));
        chk("frame0_en0_count", 32'(n_en0 - b0), 32'(FRAME_BYTES));
        chk("frame0_en1_count", 32'(n_en1 - b1), 32'(0));
        chk("frame0_buf0_full", 32'(buf0_full), 32'(1));

        // Second frame must land in buffer 1.
        b1 = n_en1;
        send_frame(FRAME_BYTES, 0);
        idle(3);
        chk("frame1_en1_count", 32'(n_en1 - b1), 32'(FRAME_BYTES));
        chk("both_full", 32'({buf1_full, buf0_full}), 32'(3));

        // Both buffers full: a third frame is held off until buffer 0 is released.
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 8'($urandom_range(0, 255)), 1'b1, a);
            chk("stalled_ready", 32'(in_ready), 32'(0));
        end
        in_valid = 1'b0;
        e_req[0] = 1'b1;
        idle(2);
        chk("release_buf0", 32'(buf0_full), 32'(0));
        b0 = n_en0;
        for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
        idle(1);
        chk("no_sof_discard", 32'(n_en0 - b0), 32'(0));
        send_frame(FRAME_BYTES, 0);
        idle(3);
        chk("frame2_en0_count", 32'(n_en0 - b0), 32'(FRAME_BYTES));

        // Release buffer 1, then abort a frame with sof on byte 151 (pixel 50, G).
        e_req[0] = 1'b0;
        e_req[1] = 1'b1;
        idle(2);
        s0 = n_sync;
        send_frame(151, 0);
        send_frame(FRAME_BYTES, 0);
        idle(3);
        chk("abort_sync_pulses", 32'(n_sync - s0), 32'(1));
        chk("abort_buf1_full", 32'(buf1_full), 32'(1));

        // Release buffer 0 and write a frame at half rate.
        e_req[1] = 1'b0;
        e_req[0] = 1'b1;
        idle(2);
        b0 = n_en0;
        send_frame(FRAME_BYTES, 1);
        idle(3);
        chk("half_rate_en0_count", 32'(n_en0 - b0), 32'(FRAME_BYTES));

        // Reset at byte 120 of a buffer-1 frame; the next frame goes to buffer 0.
        e_req[0] = 1'b0;
        e_req[1] = 1'b1;
        idle(2);
        send_frame(120, 0);
        do_reset();
        b0 = n_en0; b1 = n_en1;
        send_frame(FRAME_BYTES, 0);
        idle(3);
        chk("post_reset_en0_count", 32'(n_en0 - b0), 32'(FRAME_BYTES));
        chk("post_reset_en1_count", 32'(n_en1 - b1), 32'(0));
        chk("post_reset_full", 32'({buf1_full, buf0_full}), 32'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
